// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - requester, response and ALU-side signal bundle for alu_req_arbiter
interface alu_req_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_cin;

    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_cin;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [11:0] rsp_result;
    logic        rsp_carry;
    logic        busy;

    logic [1:0]  alu_sel;
    logic [3:0]  alu_a4;
    logic [3:0]  alu_b4;
    logic [5:0]  alu_a6;
    logic [5:0]  alu_b6;
    logic [7:0]  alu_a8;
    logic [7:0]  alu_b8;
    logic        alu_cin;
    logic [11:0] alu_result;
    logic        alu_carry;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
        input  rsp_ready, alu_result, alu_carry,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, busy,
        output alu_sel, alu_a4, alu_b4, alu_a6, alu_b6, alu_a8, alu_b8, alu_cin
    );

    // Requesters, response consumer and ALU side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_cin,
        output req1_valid, req1_op, req1_a, req1_b, req1_cin,
        output rsp_ready, alu_result, alu_carry,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, busy,
        input  alu_sel, alu_a4, alu_b4, alu_a6, alu_b6, alu_a8, alu_b8, alu_cin
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin sharing of one external ALU between two requesters
module alu_req_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state;
    logic           ptr;          // 0 favours requester 0, 1 favours requester 1
    logic [CNT_W-1:0] cnt;
    logic [1:0]     op_q;
    logic           id_q;

    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [11:0]    rsp_result_q;
    logic           rsp_carry_q;
    logic           busy_q;

    logic [1:0]     alu_sel_q;
    logic [3:0]     alu_a4_q;
    logic [3:0]     alu_b4_q;
    logic [5:0]     alu_a6_q;
    logic [5:0]     alu_b6_q;
    logic [7:0]     alu_a8_q;
    logic [7:0]     alu_b8_q;
    logic           alu_cin_q;

    logic           grant0;
    logic           grant1;
    logic [1:0]     sel_op;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;
    logic           sel_cin;

    // Round-robin grant, offered only in IDLE and never while reset is held
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == IDLE) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
            grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
        end
    end

    // Operand mux toward the granted requester
    always_comb begin
        if (grant1) begin
            sel_op  = bus.req1_op;
            sel_a   = bus.req1_a;
            sel_b   = bus.req1_b;
            sel_cin = bus.req1_cin;
        end else begin
            sel_op  = bus.req0_op;
            sel_a   = bus.req0_a;
            sel_b   = bus.req0_b;
            sel_cin = bus.req0_cin;
        end
    end

    // Main FSM: accept, hold ALU operands for the settle time, capture, present response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            cnt          <= '0;
            op_q         <= 2'b00;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            busy_q       <= 1'b0;
            alu_sel_q    <= 2'b00;
            alu_a4_q     <= '0;
            alu_b4_q     <= '0;
            alu_a6_q     <= '0;
            alu_b6_q     <= '0;
            alu_a8_q     <= '0;
            alu_b8_q     <= '0;
            alu_cin_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_q      <= sel_op;
                        id_q      <= grant1;
                        ptr       <= ~grant1;
                        cnt       <= CNT_W'(SETTLE_CYCLES);
                        busy_q    <= 1'b1;
                        state     <= SETTLE;
                        alu_sel_q <= sel_op;
                        // Ports the op does not use stay at zero
                        alu_a4_q  <= '0;
                        alu_b4_q  <= '0;
                        alu_a6_q  <= '0;
                        alu_b6_q  <= '0;
                        alu_a8_q  <= '0;
                        alu_b8_q  <= '0;
                        alu_cin_q <= sel_op[1] ? 1'b0 : sel_cin;
                        case (sel_op)
                            2'b01: begin
                                alu_a8_q <= sel_a;
                                alu_b8_q <= sel_b;
                            end
                            2'b10: begin
                                alu_a6_q <= sel_a[5:0];
                                alu_b6_q <= sel_b[5:0];
                            end
                            default: begin
                                alu_a4_q <= sel_a[3:0];
                                alu_b4_q <= sel_b[3:0];
                            end
                        endcase
                    end
                end
                SETTLE: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rsp_result_q <= bus.alu_result;
                        rsp_carry_q  <= op_q[1] ? 1'b0 : bus.alu_carry;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        alu_sel_q    <= 2'b00;
                        alu_a4_q     <= '0;
                        alu_b4_q     <= '0;
                        alu_a6_q     <= '0;
                        alu_b6_q     <= '0;
                        alu_a8_q     <= '0;
                        alu_b8_q     <= '0;
                        alu_cin_q    <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.busy       = busy_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.alu_a4     = alu_a4_q;
    assign bus.alu_b4     = alu_b4_q;
    assign bus.alu_a6     = alu_a6_q;
    assign bus.alu_b6     = alu_b6_q;
    assign bus.alu_a8     = alu_a8_q;
    assign bus.alu_b8     = alu_b8_q;
    assign bus.alu_cin    = alu_cin_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter with an external ALU model
module tb_alu_req_arbiter;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [11:0] res;
        logic        carry;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    alu_req_arbiter_if ia();
    alu_req_arbiter_if ib();

    alu_req_arbiter #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    alu_req_arbiter #(.SETTLE_CYCLES(3), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    // Shared ALU: MUL and AND report carry 1 so the arbiter's carry masking is visible
    function automatic logic [12:0] alu_fn(input logic [1:0] sel, input logic [3:0] a4, input logic [3:0] b4,
                                           input logic [5:0] a6, input logic [5:0] b6,
                                           input logic [7:0] a8, input logic [7:0] b8, input logic cin);
        logic [4:0]  s5;
        logic [8:0]  d9;
        logic [11:0] m12;
        case (sel)
            2'd0: begin
                s5 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin};
                return {s5[4], 8'd0, s5[3:0]};
            end
            2'd1: begin
                d9 = {1'b0, a8} - {1'b0, b8} - {8'd0, cin};
                return {d9[8], 4'd0, d9[7:0]};
            end
            2'd2: begin
                m12 = {6'd0, a6} * {6'd0, b6};
                return {1'b1, m12};
            end
            default: return {1'b1, 8'd0, a4 & b4};
        endcase
    endfunction

    assign {ia.alu_carry, ia.alu_result} = alu_fn(ia.alu_sel, ia.alu_a4, ia.alu_b4, ia.alu_a6, ia.alu_b6,
                                                  ia.alu_a8, ia.alu_b8, ia.alu_cin);
    assign {ib.alu_carry, ib.alu_result} = alu_fn(ib.alu_sel, ib.alu_a4, ib.alu_b4, ib.alu_a6, ib.alu_b6,
                                                  ib.alu_a8, ib.alu_b8, ib.alu_cin);

    wire [38:0] bun_a = {ia.alu_sel, ia.alu_a4, ia.alu_b4, ia.alu_a6, ia.alu_b6, ia.alu_a8, ia.alu_b8, ia.alu_cin};
    wire [38:0] bun_b = {ib.alu_sel, ib.alu_a4, ib.alu_b4, ib.alu_a6, ib.alu_b6, ib.alu_a8, ib.alu_b8, ib.alu_cin};

    // Expected result from the full request operands, using plain integer arithmetic
    function automatic rsp_t ref_fn(input logic id, input op_t o);
        rsp_t t;
        int a, b, c, r, cy;
        a = int'(o.a);
        b = int'(o.b);
        c = int'(o.cin);
        case (o.op)
            2'd0: begin r = (a % 16) + (b % 16) + c; cy = r / 16; r = r % 16; end
            2'd1: begin r = a - b - c; cy = (r < 0) ? 1 : 0; if (r < 0) r = r + 256; end
            2'd2: begin r = (a % 64) * (b % 64); cy = 0; end
            default: begin r = (a % 16) & (b % 16); cy = 0; end
        endcase
        t.id    = id;
        t.res   = r[11:0];
        t.carry = cy[0];
        return t;
    endfunction

    // Expected ALU port image while an op is being held
    function automatic logic [38:0] exp_bundle(input op_t o);
        case (o.op)
            2'd0:    return {2'd0, o.a[3:0], o.b[3:0], 12'd0, 16'd0, o.cin};
            2'd1:    return {2'd1, 8'd0, 12'd0, o.a, o.b, o.cin};
            2'd2:    return {2'd2, 8'd0, o.a[5:0], o.b[5:0], 16'd0, 1'b0};
            default: return {2'd3, o.a[3:0], o.b[3:0], 12'd0, 16'd0, 1'b0};
        endcase
    endfunction

    function automatic op_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.cin = cin;
        return o;
    endfunction

    // Transaction-level model state for instance A (settle time 1)
    op_t  q0[$];
    op_t  q1[$];
    rsp_t exp_q[$];
    rsp_t seen[$];
    int   grant_log[$];
    int   m_ptr = 0;
    int   m_left = 0;
    bit   m_resp = 1'b0;
    op_t  m_op;

    task automatic run_a(input int max_cycles, input int p_valid, input int p_ready);
        bit v0, v1, rr, idle, g0, g1, id;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (q0.size() == 0 && q1.size() == 0 && m_left == 0 && !m_resp) break;
            @(negedge clk);
            v0 = (q0.size() > 0) && ($urandom_range(99) < p_valid);
            v1 = (q1.size() > 0) && ($urandom_range(99) < p_valid);
            rr = ($urandom_range(99) < p_ready);
            ia.req0_valid = v0;
            ia.req1_valid = v1;
            if (q0.size() > 0) {ia.req0_op, ia.req0_a, ia.req0_b, ia.req0_cin} = q0[0];
            else {ia.req0_op, ia.req0_a, ia.req0_b, ia.req0_cin} = 19'($urandom);
            if (q1.size() > 0) {ia.req1_op, ia.req1_a, ia.req1_b, ia.req1_cin} = q1[0];
            else {ia.req1_op, ia.req1_a, ia.req1_b, ia.req1_cin} = 19'($urandom);
            ia.rsp_ready = rr;
            #1;
            idle = (m_left == 0) && !m_resp;
            g0 = idle && v0 && (!v1 || m_ptr == 0);
            g1 = idle && v1 && (!v0 || m_ptr == 1);
            checks++;
            if (ia.req0_ready !== g0 || ia.req1_ready !== g1) begin
                errors++;
                $display("FAIL ready got %0b%0b exp %0b%0b at %0t", ia.req0_ready, ia.req1_ready, g0, g1, $time);
            end
            checks++;
            if (ia.busy !== !idle) begin
                errors++;
                $display("FAIL busy got %0b exp %0b at %0t", ia.busy, !idle, $time);
            end
            checks++;
            if (ia.rsp_valid !== m_resp) begin
                errors++;
                $display("FAIL rsp_valid got %0b exp %0b at %0t", ia.rsp_valid, m_resp, $time);
            end
            checks++;
            if (bun_a !== ((m_left > 0) ? exp_bundle(m_op) : 39'd0)) begin
                errors++;
                $display("FAIL alu_ports got %h exp %h at %0t", bun_a, (m_left > 0) ? exp_bundle(m_op) : 39'd0, $time);
            end
            if (m_resp) begin
                checks++;
                if ({ia.rsp_id, ia.rsp_result, ia.rsp_carry} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rsp_data got id=%0b res=%h c=%0b exp id=%0b res=%h c=%0b", ia.rsp_id,
                             ia.rsp_result, ia.rsp_carry, exp_q[0].id, exp_q[0].res, exp_q[0].carry);
                end
            end
            // Advance model across the coming rising edge
            if (m_resp && rr) begin
                seen.push_back({ia.rsp_id, ia.rsp_result, ia.rsp_carry});
                void'(exp_q.pop_front());
                m_resp = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_resp = 1'b1;
            end else if (g0 || g1) begin
                id = g1;
                m_op = id ? q1.pop_front() : q0.pop_front();
                exp_q.push_back(ref_fn(id, m_op));
                grant_log.push_back(int'(id));
                m_ptr = id ? 0 : 1;
                m_left = 1;
            end
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || m_left != 0 || m_resp) begin
            errors++;
            $display("FAIL drain timeout pending q0=%0d q1=%0d", q0.size(), q1.size());
            q0.delete(); q1.delete(); exp_q.delete();
        end
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        {ia.req0_op, ia.req0_a, ia.req0_b, ia.req0_cin} = '0;
        {ia.req1_op, ia.req1_a, ia.req1_b, ia.req1_cin} = '0;
        {ib.req0_op, ib.req0_a, ib.req0_b, ib.req0_cin} = '0;
        {ib.req1_op, ib.req1_a, ib.req1_b, ib.req1_cin} = '0;
        ia.rsp_ready = 1'b0;
        ib.rsp_ready = 1'b0;
        ia.req0_valid = 1'b1;
        ia.req1_valid = 1'b0;
        ib.req0_valid = 1'b0;
        ib.req1_valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ia.req0_ready !== 1'b0 || ib.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %0b %0b exp 0 0", ia.req0_ready, ib.req1_ready);
        end
        checks++;
        if ({ia.rsp_valid, ia.busy, ia.rsp_id, ia.rsp_result, ia.rsp_carry, bun_a} !== '0) begin
            errors++;
            $display("FAIL reset_a_outputs got %h exp 0", {ia.rsp_valid, ia.busy, ia.rsp_id, ia.rsp_result, ia.rsp_carry, bun_a});
        end
        checks++;
        if ({ib.rsp_valid, ib.busy, ib.rsp_id, ib.rsp_result, ib.rsp_carry, bun_b} !== '0) begin
            errors++;
            $display("FAIL reset_b_outputs got %h exp 0", {ib.rsp_valid, ib.busy, ib.rsp_id, ib.rsp_result, ib.rsp_carry, bun_b});
        end
        ia.req0_valid = 1'b0;
        ib.req1_valid = 1'b0;
        rst_n = 1'b1;
        m_ptr = 0; m_left = 0; m_resp = 1'b0;
    endtask

    task automatic test_back_to_back();
        int exp_g[4] = '{0, 1, 0, 1};
        seen.delete();
        grant_log.delete();
        q0.push_back(mk(2'd3, 8'h0D, 8'h0A, 1'b0));
        q0.push_back(mk(2'd2, 8'd7, 8'd9, 1'b0));
        q1.push_back(mk(2'd0, 8'd1, 8'd1, 1'b0));
        q1.push_back(mk(2'd1, 8'd50, 8'd20, 1'b1));
        run_a(40, 100, 100);
        checks++;
        if (grant_log.size() != 4 || seen.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d grants %0d rsps exp 4 4", grant_log.size(), seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] != exp_g[i]) begin
                    errors++;
                    $display("FAIL b2b_grant%0d got %0d exp %0d", i, grant_log[i], exp_g[i]);
                end
            end
            checks++;
            if (seen[0].res !== 12'h008 || seen[1].res !== 12'h002) begin
                errors++;
                $display("FAIL b2b_results got %h %h exp 008 002", seen[0].res, seen[1].res);
            end
        end
    endtask

    task automatic test_directed();
        seen.delete();
        q0.push_back(mk(2'd0, 8'd5, 8'd3, 1'b0));
        run_a(20, 100, 100);
        q1.push_back(mk(2'd1, 8'd100, 8'd25, 1'b0));
        run_a(20, 100, 100);
        q0.push_back(mk(2'd2, 8'd15, 8'd3, 1'b0));
        run_a(20, 100, 100);
        checks++;
        if (seen.size() != 3) begin
            errors++;
            $display("FAIL directed_count got %0d exp 3", seen.size());
        end else begin
            checks++;
            if (seen[0] !== rsp_t'({1'b0, 12'h008, 1'b0})) begin
                errors++;
                $display("FAIL directed_add got %h exp %h", seen[0], rsp_t'({1'b0, 12'h008, 1'b0}));
            end
            checks++;
            if (seen[1].id !== 1'b1 || seen[1].res !== 12'h04B) begin
                errors++;
                $display("FAIL directed_sub got id=%0b res=%h exp id=1 res=04b", seen[1].id, seen[1].res);
            end
            checks++;
            if (seen[2].res !== 12'h02D || seen[2].carry !== 1'b0) begin
                errors++;
                $display("FAIL directed_mul got res=%h c=%0b exp res=02d c=0", seen[2].res, seen[2].carry);
            end
        end
    endtask

    task automatic test_backpressure();
        bit got;
        @(negedge clk);
        ia.req0_valid = 1'b1;
        {ia.req0_op, ia.req0_a, ia.req0_b, ia.req0_cin} = {2'd0, 8'd9, 8'd9, 1'b1};
        ia.rsp_ready = 1'b0;
        @(negedge clk);
        ia.req0_valid = 1'b0;
        m_ptr = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (ia.rsp_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_wait rsp_valid got 0 exp 1");
        end
        ia.req0_valid = 1'b1;
        ia.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({ia.rsp_valid, ia.rsp_result, ia.rsp_carry, ia.busy, ia.req0_ready, ia.req1_ready} !==
                {1'b1, 12'h003, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0b res=%h c=%0b busy=%0b rdy=%0b%0b exp v=1 res=003 c=1 busy=1 rdy=00",
                         i, ia.rsp_valid, ia.rsp_result, ia.rsp_carry, ia.busy, ia.req0_ready, ia.req1_ready);
            end
        end
        @(negedge clk);
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;
        ia.rsp_ready = 1'b1;
        @(negedge clk);
        ia.rsp_ready = 1'b0;
        #1;
        checks++;
        if (ia.busy !== 1'b0 || ia.rsp_valid !== 1'b0 || ia.rsp_result !== 12'h003) begin
            errors++;
            $display("FAIL bp_release got busy=%0b v=%0b res=%h exp busy=0 v=0 res=003", ia.busy, ia.rsp_valid, ia.rsp_result);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            q0.push_back(op_t'($urandom));
            q1.push_back(op_t'($urandom));
        end
        run_a(3000, 60, 60);
    endtask

    task automatic test_settle3();
        op_t o;
        o = mk(2'd1, 8'd200, 8'd55, 1'b1);
        @(negedge clk);
        ib.req0_valid = 1'b1;
        {ib.req0_op, ib.req0_a, ib.req0_b, ib.req0_cin} = o;
        ib.rsp_ready = 1'b1;
        #1;
        checks++;
        if (ib.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL s3_accept ready got %0b exp 1", ib.req0_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ib.req0_valid = 1'b0;
                {ib.req0_op, ib.req0_a, ib.req0_b, ib.req0_cin} = 19'($urandom);
            end
            #1;
            checks++;
            if (bun_b !== exp_bundle(o) || ib.rsp_valid !== 1'b0 || ib.busy !== 1'b1) begin
                errors++;
                $display("FAIL s3_hold%0d got ports=%h v=%0b busy=%0b exp ports=%h v=0 busy=1", k, bun_b,
                         ib.rsp_valid, ib.busy, exp_bundle(o));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({ib.rsp_valid, ib.rsp_id, ib.rsp_result, ib.rsp_carry, bun_b} !== {1'b1, 1'b0, 12'h090, 1'b0, 39'd0}) begin
            errors++;
            $display("FAIL s3_resp got v=%0b id=%0b res=%h c=%0b ports=%h exp v=1 id=0 res=090 c=0 ports=0",
                     ib.rsp_valid, ib.rsp_id, ib.rsp_result, ib.rsp_carry, bun_b);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ib.rsp_valid !== 1'b0 || ib.busy !== 1'b0) begin
            errors++;
            $display("FAIL s3_done got v=%0b busy=%0b exp 0 0", ib.rsp_valid, ib.busy);
        end
    endtask

    task automatic test_reset_mid_settle();
        @(negedge clk);
        ib.req0_valid = 1'b1;
        {ib.req0_op, ib.req0_a, ib.req0_b, ib.req0_cin} = {2'd0, 8'd3, 8'd4, 1'b0};
        ib.rsp_ready = 1'b1;
        @(negedge clk);
        ib.req0_valid = 1'b0;
        #1;
        checks++;
        if (ib.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre busy got %0b exp 1", ib.busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ib.rsp_valid, ib.busy, bun_b} !== '0) begin
            errors++;
            $display("FAIL rst_async got v=%0b busy=%0b ports=%h exp all 0", ib.rsp_valid, ib.busy, bun_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0; m_left = 0; m_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ib.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_resp%0d rsp_valid got %0b exp 0", i, ib.rsp_valid);
            end
        end
        @(negedge clk);
        ib.req0_valid = 1'b1;
        ib.req1_valid = 1'b1;
        #1;
        checks++;
        if (ib.req0_ready !== 1'b1 || ib.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ptr got rdy=%0b%0b exp 10", ib.req0_ready, ib.req1_ready);
        end
        #1;
        ib.req0_valid = 1'b0;
        ib.req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_backpressure();
        test_random();
        test_settle3();
        test_reset_mid_settle();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational ALU instance between two independent requesters. The ALU provides 4-bit ADD, 8-bit SUB, 6-bit MUL and 4-bit AND.
- Arbitrates round-robin and slices each request's operands onto the ALU operand ports.
- Holds the ALU inputs stable for a configurable settle time, then registers the result and returns it on a valid/ready response channel tagged with the requester ID.
- Sits between client blocks and the ALU; the ALU is instantiated beside it, not inside it.

Parameters:
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 handshake accepted this cycle
- req0_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 AND
- req0_a, req0_b  input  8  operands
- req0_cin  input  1  carry/borrow in
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_cin  same widths and meaning, requester 1
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the operation
- rsp_result  output  12  captured ALU result
- rsp_carry  output  1  captured carry/borrow out
- busy  output  1  high in every state except IDLE
- alu_sel  output  2  to ALU
- alu_a4, alu_b4  output  4  to ALU A_4/B_4
- alu_a6, alu_b6  output  6  to ALU A_6/B_6
- alu_a8, alu_b8  output  8  to ALU A_8/B_8
- alu_cin  output  1  to ALU carry_in
- alu_result  input  12  from ALU result
- alu_carry  input  1  from ALU carry_out

Behaviour:
- Reset (asynchronous, rst_n low): the block enters IDLE immediately, not waiting for a clock edge.
  - Cleared to 0: rsp_valid, rsp_id, rsp_result, rsp_carry, busy, req0_ready, req1_ready, all alu_* outputs, settle counter.
  - The round-robin pointer is set to favour requester 0.
  - An in-flight operation or unaccepted response is discarded.
- States are IDLE, SETTLE and RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the granted requester; the ungranted requester's ready is 0.
  - Grant rule: if only one valid, grant it. If both valid, grant the one the pointer favours.
  - On an accept edge (valid & ready):
    - Latch op, a, b, cin and id.
    - Move the pointer to favour the other requester.
    - Load the counter with SETTLE_CYCLES and go to SETTLE.
  - With no valid inputs, stay in IDLE and leave the pointer unchanged.
- ALU drive:
  - alu_* outputs are registered, loaded on the accept edge and held constant through SETTLE.
  - Slicing by latched op:
    - 00: alu_a4/alu_b4 = a[3:0]/b[3:0]
    - 01: alu_a8/alu_b8 = a/b
    - 10: alu_a6/alu_b6 = a[5:0]/b[5:0]
    - 11: alu_a4/alu_b4 = a[3:0]/b[3:0]
  - ALU operand ports not used by the op are driven 0. alu_sel equals the op; alu_cin equals cin for ops 00/01 and 0 otherwise.
  - On the edge leaving SETTLE, every alu_* output returns to 0.
- SETTLE:
  - The counter decrements each cycle.
  - On the edge where the counter is 1, capture alu_result into rsp_result unchanged.
  - rsp_carry = alu_carry for ops 00/01 and 0 for ops 10/11.
  - Go to RESP.
  - With SETTLE_CYCLES=1, rsp_valid rises exactly one cycle after the accept edge.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_carry stay stable until handshake; both reqN_ready are 0.
  - On rsp_valid & rsp_ready, return to IDLE; rsp_valid falls and the rsp_* data holds its last value.
  - There is no accept in the same cycle as the response handshake. The minimum issue interval is SETTLE_CYCLES+2 cycles.
- Input changes: changes to reqN_* inputs after acceptance have no effect on the in-flight operation. A requester that deasserts valid before being granted loses nothing.

Test Plan:
- After reset, req0 ADD a=5 b=3 cin=0, rsp_ready=1 → one cycle after accept: rsp_valid=1, rsp_id=0, rsp_result=0x008, rsp_carry=0. alu_a8/b8/a6/b6 stay 0 throughout.
- req1 SUB a=100 b=25 → rsp_id=1, rsp_result=0x04B. Then req0 MUL a=15 b=3 → rsp_result=0x02D, rsp_carry=0.
- Both valid every cycle, four ops queued (req0 AND 0xD&0xA, req1 ADD 1+1, …) → grants alternate 0,1,0,1; first AND response is 0x008, the ADD response is 0x002. The ungranted ready is never high.
- rsp_ready held low 5 cycles in RESP → rsp_valid and rsp_result are constant, req*_ready=0 and busy=1; one cycle after rsp_ready rises, busy=0.
- SETTLE_CYCLES=3 → alu_* inputs constant for 3 cycles, then rsp_valid rises 3 cycles after accept.
- rst_n pulsed low mid-SETTLE → rsp_valid, busy and all alu_* outputs go 0 without a clock edge; no response is emitted afterwards, and the next grant with both valid goes to req0.
